// File: rtl/game_pkg.sv
// Shared types and constants for the cat-vs-dog game-flow blocks.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WIND,
    AIM,
    FLIGHT,
    NEXT,
    OVER
  } turn_state_t;

  localparam logic PLAYER_CAT = 1'b0;
  localparam logic PLAYER_DOG = 1'b1;

  localparam int SCORE_W = 3;
  localparam int TURN_W  = 3;

  // Score increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    sat_inc = (s == {SCORE_W{1'b1}}) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter shared by all timed game phases; stops at zero.
module turn_timer #(
  parameter int TW = 30
) (
  input  logic          clk60MHz,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/turn_controller.sv
// Game-flow sequencer: alternates players, gates fire requests into launch
// pulses, scores projectile outcomes and declares the winner.
module turn_controller
  import game_pkg::*;
#(
  parameter int HITS_TO_WIN    = 3,
  parameter int WIND_SETTLE    = 2,
  parameter int AIM_TIMEOUT    = 300_000_000,
  parameter int FLIGHT_TIMEOUT = 600_000_000,
  parameter int TW             = 30
) (
  input  logic              clk60MHz,
  input  logic              rst,
  input  logic              start,
  input  logic              fire_req_cat,
  input  logic              fire_req_dog,
  input  logic              proj_done,
  input  logic              proj_hit,
  output logic [TURN_W-1:0]  turn,
  output logic              active_player,
  output logic              fire,
  output logic              aim_en,
  output logic [SCORE_W-1:0] score_cat,
  output logic [SCORE_W-1:0] score_dog,
  output logic              turn_forfeit,
  output logic              game_over,
  output logic              winner
);

  localparam logic [TW-1:0] WIND_LOAD   = TW'(WIND_SETTLE - 1);
  localparam logic [TW-1:0] AIM_LOAD    = TW'(AIM_TIMEOUT - 1);
  localparam logic [TW-1:0] FLIGHT_LOAD = TW'(FLIGHT_TIMEOUT - 1);

  turn_state_t        state_q, state_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic               player_q, player_d;
  logic               fire_q, fire_d;
  logic               aim_en_q, aim_en_d;
  logic [SCORE_W-1:0] score_cat_q, score_cat_d;
  logic [SCORE_W-1:0] score_dog_q, score_dog_d;
  logic               forfeit_q, forfeit_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  logic               timer_load;
  logic [TW-1:0]      timer_val;
  logic               timer_zero;
  logic               active_req;
  logic [SCORE_W-1:0] new_score;

  turn_timer #(.TW(TW)) u_timer (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Only the player whose turn it is may launch; the other request is dropped.
  assign active_req = (player_q == PLAYER_DOG) ? fire_req_dog : fire_req_cat;
  assign new_score  = sat_inc((player_q == PLAYER_DOG) ? score_dog_q : score_cat_q);

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    player_d    = player_q;
    fire_d      = 1'b0;
    aim_en_d    = aim_en_q;
    score_cat_d = score_cat_q;
    score_dog_d = score_dog_q;
    forfeit_d   = 1'b0;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    timer_load  = 1'b0;
    timer_val   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WIND;
          timer_load = 1'b1;
          timer_val  = WIND_LOAD;
        end
      end
      WIND: begin
        if (timer_zero) begin
          state_d    = AIM;
          aim_en_d   = 1'b1;
          timer_load = 1'b1;
          timer_val  = AIM_LOAD;
        end
      end
      AIM: begin
        if (active_req) begin
          state_d    = FLIGHT;
          fire_d     = 1'b1;
          aim_en_d   = 1'b0;
          timer_load = 1'b1;
          timer_val  = FLIGHT_LOAD;
        end else if (timer_zero) begin
          state_d   = NEXT;
          forfeit_d = 1'b1;
          aim_en_d  = 1'b0;
        end
      end
      FLIGHT: begin
        // A landing report takes priority over a watchdog expiry in the same cycle.
        if (proj_done) begin
          if (proj_hit) begin
            if (player_q == PLAYER_DOG) begin
              score_dog_d = new_score;
            end else begin
              score_cat_d = new_score;
            end
          end
          if (proj_hit && (new_score == SCORE_W'(HITS_TO_WIN))) begin
            state_d     = OVER;
            game_over_d = 1'b1;
            winner_d    = player_q;
          end else begin
            state_d = NEXT;
          end
        end else if (timer_zero) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        state_d    = WIND;
        turn_d     = turn_q + TURN_W'(1);
        player_d   = ~player_q;
        timer_load = 1'b1;
        timer_val  = WIND_LOAD;
      end
      OVER: begin
        if (start) begin
          state_d     = WIND;
          turn_d      = '0;
          player_d    = PLAYER_CAT;
          score_cat_d = '0;
          score_dog_d = '0;
          game_over_d = 1'b0;
          timer_load  = 1'b1;
          timer_val   = WIND_LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q     <= IDLE;
      turn_q      <= '0;
      player_q    <= PLAYER_CAT;
      fire_q      <= 1'b0;
      aim_en_q    <= 1'b0;
      score_cat_q <= '0;
      score_dog_q <= '0;
      forfeit_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      player_q    <= player_d;
      fire_q      <= fire_d;
      aim_en_q    <= aim_en_d;
      score_cat_q <= score_cat_d;
      score_dog_q <= score_dog_d;
      forfeit_q   <= forfeit_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign turn          = turn_q;
  assign active_player = player_q;
  assign fire          = fire_q;
  assign aim_en        = aim_en_q;
  assign score_cat     = score_cat_q;
  assign score_dog     = score_dog_q;
  assign turn_forfeit  = forfeit_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed game scenarios plus a randomized run
// compared cycle by cycle against a phase/cycles-remaining reference model.
module tb_turn_controller;

  localparam int HITS = 3;
  localparam int WS   = 2;
  localparam int AT   = 10;
  localparam int FT   = 20;

  logic       clk60MHz = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       fire_req_cat = 1'b0;
  logic       fire_req_dog = 1'b0;
  logic       proj_done = 1'b0;
  logic       proj_hit = 1'b0;
  logic [2:0] turn;
  logic       active_player;
  logic       fire;
  logic       aim_en;
  logic [2:0] score_cat;
  logic [2:0] score_dog;
  logic       turn_forfeit;
  logic       game_over;
  logic       winner;

  int total = 0;
  int bad = 0;

  turn_controller #(
    .HITS_TO_WIN    (HITS),
    .WIND_SETTLE    (WS),
    .AIM_TIMEOUT    (AT),
    .FLIGHT_TIMEOUT (FT),
    .TW             (30)
  ) dut (
    .clk60MHz      (clk60MHz),
    .rst           (rst),
    .start         (start),
    .fire_req_cat  (fire_req_cat),
    .fire_req_dog  (fire_req_dog),
    .proj_done     (proj_done),
    .proj_hit      (proj_hit),
    .turn          (turn),
    .active_player (active_player),
    .fire          (fire),
    .aim_en        (aim_en),
    .score_cat     (score_cat),
    .score_dog     (score_dog),
    .turn_forfeit  (turn_forfeit),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #8 clk60MHz = ~clk60MHz;

  logic [14:0] dut_vec;
  assign dut_vec = {turn, active_player, fire, aim_en, score_cat, score_dog,
                    turn_forfeit, game_over, winner};

  // Reference model: game phase plus number of cycles left in that phase.
  localparam int M_IDLE = 0, M_WIND = 1, M_AIM = 2, M_FLIGHT = 3, M_NEXT = 4, M_OVER = 5;
  int m_phase = M_IDLE;
  int m_left = 0;
  int m_turn = 0;
  int m_pl = 0;
  int m_fire = 0;
  int m_aim = 0;
  int m_sc[2] = '{0, 0};
  int m_forf = 0;
  int m_go = 0;
  int m_win = 0;

  function automatic logic [14:0] model_vec();
    logic [2:0] t, sc0, sc1;
    t   = 3'(m_turn);
    sc0 = 3'(m_sc[0]);
    sc1 = 3'(m_sc[1]);
    return {t, m_pl[0], m_fire[0], m_aim[0], sc0, sc1, m_forf[0], m_go[0], m_win[0]};
  endfunction

  task automatic model_step();
    int req;
    if (rst) begin
      m_phase = M_IDLE; m_left = 0; m_turn = 0; m_pl = 0; m_fire = 0; m_aim = 0;
      m_sc[0] = 0; m_sc[1] = 0; m_forf = 0; m_go = 0; m_win = 0;
      return;
    end
    m_fire = 0;
    m_forf = 0;
    case (m_phase)
      M_IDLE: if (start) begin m_phase = M_WIND; m_left = WS; end
      M_WIND: begin
        if (m_left == 1) begin m_phase = M_AIM; m_left = AT; m_aim = 1; end
        else m_left--;
      end
      M_AIM: begin
        req = (m_pl == 1) ? int'(fire_req_dog) : int'(fire_req_cat);
        if (req == 1) begin m_phase = M_FLIGHT; m_left = FT; m_fire = 1; m_aim = 0; end
        else if (m_left == 1) begin m_phase = M_NEXT; m_forf = 1; m_aim = 0; end
        else m_left--;
      end
      M_FLIGHT: begin
        if (proj_done) begin
          if (proj_hit && m_sc[m_pl] < 7) m_sc[m_pl]++;
          if (proj_hit && m_sc[m_pl] == HITS) begin
            m_phase = M_OVER; m_go = 1; m_win = m_pl;
          end else m_phase = M_NEXT;
        end else if (m_left == 1) m_phase = M_NEXT;
        else m_left--;
      end
      M_NEXT: begin
        m_turn = (m_turn + 1) % 8; m_pl = 1 - m_pl; m_phase = M_WIND; m_left = WS;
      end
      M_OVER: begin
        if (start) begin
          m_sc[0] = 0; m_sc[1] = 0; m_turn = 0; m_pl = 0; m_go = 0;
          m_phase = M_WIND; m_left = WS;
        end
      end
      default: m_phase = M_IDLE;
    endcase
  endtask

  // One clock: present inputs, let the edge happen, advance the model, settle.
  task automatic tick(input logic s, input logic fc, input logic fd,
                      input logic pd, input logic ph);
    start = s; fire_req_cat = fc; fire_req_dog = fd; proj_done = pd; proj_hit = ph;
    @(posedge clk60MHz);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic wait_aim(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (aim_en === 1'b1) begin ok = 1'b1; break; end
      tick(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dut_vec !== 15'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", dut_vec, 15'd0);
    end
    tick(0, 1, 1, 1, 1);
    tick(0, 1, 0, 1, 1);
    total++;
    if (dut_vec !== 15'd0) begin
      bad++; $display("FAIL idle_ignores_inputs got=%h want=%h", dut_vec, 15'd0);
    end
  endtask

  task automatic test_start_wind();
    tick(1, 0, 0, 0, 0);
    total++;
    if (aim_en !== 1'b0) begin
      bad++; $display("FAIL wind_cycle1_aim got=%b want=0", aim_en);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if (aim_en !== 1'b0) begin
      bad++; $display("FAIL wind_cycle2_aim got=%b want=0", aim_en);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if ({aim_en, turn, active_player} !== {1'b1, 3'd0, 1'b0}) begin
      bad++; $display("FAIL aim_entry got aim=%b turn=%0d pl=%b want aim=1 turn=0 pl=0",
                      aim_en, turn, active_player);
    end
  endtask

  task automatic test_fire_gating();
    tick(0, 0, 1, 0, 0);
    total++;
    if ({fire, aim_en} !== 2'b01) begin
      bad++; $display("FAIL inactive_fire_ignored got fire=%b aim=%b want fire=0 aim=1", fire, aim_en);
    end
    tick(0, 1, 1, 0, 0);
    total++;
    if ({fire, aim_en} !== 2'b10) begin
      bad++; $display("FAIL active_fire_launch got fire=%b aim=%b want fire=1 aim=0", fire, aim_en);
    end
    tick(0, 1, 0, 0, 0);
    total++;
    if (fire !== 1'b0) begin
      bad++; $display("FAIL fire_single_cycle got=%b want=0", fire);
    end
  endtask

  task automatic test_hit();
    tick(0, 0, 0, 1, 1);
    total++;
    if ({score_cat, score_dog, game_over} !== {3'd1, 3'd0, 1'b0}) begin
      bad++; $display("FAIL cat_hit_score got cat=%0d dog=%0d go=%b want cat=1 dog=0 go=0",
                      score_cat, score_dog, game_over);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if ({turn, active_player, aim_en} !== {3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL next_turn got turn=%0d pl=%b aim=%b want turn=1 pl=1 aim=0",
                      turn, active_player, aim_en);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if (aim_en !== 1'b0) begin
      bad++; $display("FAIL dog_wind_cycle2 got aim=%b want=0", aim_en);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if (aim_en !== 1'b1) begin
      bad++; $display("FAIL dog_aim_entry got aim=%b want=1", aim_en);
    end
  endtask

  task automatic test_forfeit();
    int n;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, 0, 0, 0);
      if (aim_en === 1'b1) n++;
      else break;
    end
    total++;
    if (n != AT || turn_forfeit !== 1'b1) begin
      bad++; $display("FAIL aim_timeout got aim_cycles=%0d forfeit=%b want aim_cycles=%0d forfeit=1",
                      n, turn_forfeit, AT);
    end
    total++;
    if ({score_cat, score_dog} !== {3'd1, 3'd0}) begin
      bad++; $display("FAIL forfeit_scores got cat=%0d dog=%0d want cat=1 dog=0", score_cat, score_dog);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if ({turn, active_player, turn_forfeit} !== {3'd2, 1'b0, 1'b0}) begin
      bad++; $display("FAIL after_forfeit got turn=%0d pl=%b forfeit=%b want turn=2 pl=0 forfeit=0",
                      turn, active_player, turn_forfeit);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int exp_turn;
    do_reset();
    tick(1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      wait_aim(ok);
      for (int i = 0; i < 40 && turn_forfeit !== 1'b1; i++) tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      exp_turn = (k + 1) % 8;
      total++;
      if (!ok || turn !== 3'(exp_turn) || active_player !== exp_turn[0]) begin
        bad++; $display("FAIL wrap_turn_%0d got turn=%0d pl=%b want turn=%0d pl=%0d",
                        k, turn, active_player, exp_turn, exp_turn % 2);
      end
    end
  endtask

  task automatic test_win_and_restart();
    bit ok;
    logic [14:0] held;
    do_reset();
    tick(1, 0, 0, 0, 0);
    for (int shot = 0; shot < 12; shot++) begin
      wait_aim(ok);
      if (active_player == 1'b0) begin
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 1);
      end else begin
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 0);
      end
      if (game_over === 1'b1) break;
    end
    total++;
    if ({game_over, winner, score_cat, score_dog, turn} !== {1'b1, 1'b0, 3'd3, 3'd0, 3'd4}) begin
      bad++; $display("FAIL cat_wins got go=%b win=%b cat=%0d dog=%0d turn=%0d want go=1 win=0 cat=3 dog=0 turn=4",
                      game_over, winner, score_cat, score_dog, turn);
    end
    held = dut_vec;
    tick(0, 1, 1, 1, 1);
    tick(0, 0, 0, 1, 1);
    total++;
    if (dut_vec !== held || dut_vec !== model_vec()) begin
      bad++; $display("FAIL over_holds got=%h want=%h", dut_vec, model_vec());
    end
    tick(1, 0, 0, 0, 0);
    total++;
    if ({game_over, score_cat, score_dog, turn, active_player} !== {1'b0, 3'd0, 3'd0, 3'd0, 1'b0}) begin
      bad++; $display("FAIL restart_clear got go=%b cat=%0d dog=%0d turn=%0d pl=%b want all zero",
                      game_over, score_cat, score_dog, turn, active_player);
    end
    wait_aim(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL restart_resume got aim=%b want=1 within budget", aim_en);
    end
  endtask

  task automatic test_rst_in_flight();
    bit ok;
    do_reset();
    tick(1, 0, 0, 0, 0);
    wait_aim(ok);
    tick(0, 1, 0, 0, 0);
    rst = 1'b1;
    tick(0, 0, 0, 0, 0);
    rst = 1'b0;
    total++;
    if (!ok || dut_vec !== 15'd0) begin
      bad++; $display("FAIL rst_in_flight got=%h want=%h", dut_vec, 15'd0);
    end
    tick(0, 0, 0, 1, 1);
    total++;
    if (dut_vec !== 15'd0) begin
      bad++; $display("FAIL stale_proj_done got=%h want=%h", dut_vec, 15'd0);
    end
  endtask

  task automatic test_random();
    int errs;
    logic s, fc, fd, pd, ph;
    errs = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 15) == 0);
      fc  = ($urandom_range(0, 5) == 0);
      fd  = ($urandom_range(0, 5) == 0);
      pd  = ($urandom_range(0, 4) == 0);
      ph  = ($urandom_range(0, 1) == 1);
      tick(s, fc, fd, pd, ph);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle_%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_wind();
    test_fire_gating();
    test_hit();
    test_forfeit();
    test_wrap();
    test_win_and_restart();
    test_rst_in_flight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Game-flow sequencer for the cat-vs-dog artillery game.
- Owns the round counter `turn[2:0]` that feeds the wind generator, and alternates the active player (cat/dog).
- Gates fire requests into one-cycle launch pulses for the projectile engine, waits for the projectile outcome, keeps score and declares game over.
- Sits between the player input logic and the mechanics blocks (wind, projectile), all in the clk60MHz domain.

Parameters:
- HITS_TO_WIN, 3, hits needed to win (1..7).
- WIND_SETTLE, 2, cycles spent in WIND before aiming is allowed (covers the 1-cycle registered wind latency plus margin); must be ≥1.
- AIM_TIMEOUT, 300_000_000, cycles allowed in AIM before the turn is forfeited (5 s).
- FLIGHT_TIMEOUT, 600_000_000, watchdog cycles in FLIGHT; on expiry the shot counts as a miss.
- TW, 30, width of the shared timeout counter; must hold max(AIM_TIMEOUT, FLIGHT_TIMEOUT).

Ports:
- clk60MHz  input  1  system clock, 60 MHz.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; starts a game from IDLE or OVER.
- fire_req_cat  input  1  one-cycle fire pulse from the cat player.
- fire_req_dog  input  1  one-cycle fire pulse from the dog player.
- proj_done  input  1  one-cycle pulse from the projectile engine: the shot has landed.
- proj_hit  input  1  valid with proj_done; 1 = target hit.
- turn  output  3  round counter, drives the wind generator.
- active_player  output  1  0 = cat, 1 = dog.
- fire  output  1  one-cycle launch pulse to the projectile engine.
- aim_en  output  1  high while in AIM (player may fire).
- score_cat  output  3  cat hit count.
- score_dog  output  3  dog hit count.
- turn_forfeit  output  1  one-cycle pulse when an AIM timeout forfeits the turn.
- game_over  output  1  high in OVER.
- winner  output  1  valid while game_over; player that won.

Behaviour:
- All outputs are registered. Reset values: turn=0, active_player=0, fire=0, aim_en=0, scores=0, turn_forfeit=0, game_over=0, winner=0, state=IDLE, timer=0.
- rst takes effect in any state, including mid-flight. Any outstanding proj_done is then ignored because the FSM is in IDLE.
- States: IDLE, WIND, AIM, FLIGHT, NEXT, OVER.
- IDLE: start → WIND next cycle; timer loads WIND_SETTLE-1. Other inputs are ignored.
- WIND: timer counts down; at 0 → AIM. aim_en rises in the same cycle the state becomes AIM. Duration is exactly WIND_SETTLE cycles.
- AIM, firing:
  - The active player's fire_req sampled high at edge N → fire=1 during cycle N+1 only, state=FLIGHT at N+1, timer loads FLIGHT_TIMEOUT-1.
  - The inactive player's request is ignored. If both are high, only the active one counts.
- AIM, timeout: timer reaches 0 with no valid request → turn_forfeit pulses for 1 cycle, state → NEXT. Scores are unchanged.
- FLIGHT:
  - proj_done at edge N → at N+1:
    - if proj_hit, the active player's score increments (saturating at 7);
    - if the new score == HITS_TO_WIN → OVER (game_over=1, winner=active_player, turn frozen); otherwise → NEXT.
  - Watchdog expiry → NEXT as a miss.
  - fire_req inputs are ignored.
- proj_done/proj_hit outside FLIGHT are ignored.
- NEXT: a single cycle. turn ← turn+1, wrapping 7→0 modulo 2^3. active_player toggles. Timer loads WIND_SETTLE-1. → WIND.
- OVER: outputs are held. start → scores cleared, turn=0, active_player=0, game_over=0 → WIND.
- start is ignored in WIND/AIM/FLIGHT/NEXT.
- Timer: one TW-bit down-counter shared between states, reloaded on every state entry listed above.

Decomposition:
- Package game_pkg:
  - state enum turn_state_t {IDLE, WIND, AIM, FLIGHT, NEXT, OVER};
  - player constants PLAYER_CAT=1'b0, PLAYER_DOG=1'b1;
  - SCORE_W=3, TURN_W=3 (shared with the wind generator).
- Sub-module: turn_timer, a loadable down-counter (load, load_val, zero flag). Everything else is the FSM in turn_controller.

Test Plan:
- Reset then start at cycle 0: WIND for WIND_SETTLE=2 cycles, aim_en=1 from cycle 3, turn=0, active_player=0.
- In AIM (cat), pulse fire_req_dog, then fire_req_cat: dog is ignored; fire is high exactly 1 cycle after the cat request; state FLIGHT.
- In FLIGHT, proj_done=1 with proj_hit=1: score_cat 0→1, then NEXT; turn=1, active_player=1; aim_en returns after 2 WIND cycles.
- With AIM_TIMEOUT=10 (sim override) and no request: turn_forfeit pulses at cycle 10 of AIM; turn increments; scores unchanged.
- Run 8 forfeited turns: turn sequence 1..7,0 (wrap), active_player alternates.
- Cat scores 3 hits: game_over=1, winner=0; extra proj_done is ignored; start clears scores, turn=0, play resumes. Assert rst during FLIGHT: all outputs return to reset values the next cycle.
